// File: rtl/dotp_pkg.sv
// Shared types and default widths for the dot-product sequencer and its accumulator.
package dotp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 48;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/dotp_accumulator.sv
// Sign-extending accumulator with sticky signed-overflow flag and saturating element counter.
module dotp_accumulator
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  acc_en_i,
  input  logic [DATA_WIDTH-1:0] product_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, addend, sum;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_hit;

  assign addend  = ACC_WIDTH'($signed(product_i));
  assign sum     = acc_q + addend;
  // Signed overflow: both operands share a sign that the wrapped sum does not.
  assign ovf_hit = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (acc_en_i) begin
      acc_d = sum;
      ovf_d = ovf_q | ovf_hit;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o   = acc_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/dot_product_sequencer_32.sv
// Valid/ready controller that feeds operand pairs to an external multiplier and accumulates a dot product.
module dot_product_sequencer_32
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mul_multiplier,
  output logic [DATA_WIDTH-1:0] mul_multiplicand,
  output logic                  mul_start,
  input  logic [DATA_WIDTH-1:0] mul_product,
  input  logic                  mul_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  last_q;
  logic                  live_q;
  logic                  hold_q, hold_d;
  logic                  load_op, acc_en, acc_clr;

  // in_ready stays low until the first clock edge after reset release.
  assign in_ready  = (state_q == IDLE) && live_q && !clear;
  assign load_op   = in_valid && in_ready;
  assign mul_start = (state_q == ISSUE);
  assign out_valid = (state_q == DONE);

  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;

  always_comb begin
    state_d = state_q;
    hold_d  = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear)        acc_clr = 1'b1;
        else if (load_op) state_d = ISSUE;
      end
      ISSUE: begin
        if (clear) begin
          acc_clr = 1'b1;
          hold_d  = 1'b1;  // multiplier may still show ready the cycle after start
          state_d = DRAIN;
        end else begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (clear) begin
          acc_clr = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (clear) begin
          acc_clr = 1'b1;
          state_d = DRAIN;
        end else if (mul_ready) begin
          acc_en  = 1'b1;
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (clear || out_ready) begin
          acc_clr = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!hold_q && mul_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
    end else if (load_op) begin
      a_q    <= in_a;
      b_q    <= in_b;
      last_q <= in_last;
    end
  end

  dotp_accumulator #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_acc (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (acc_clr),
    .acc_en_i (acc_en),
    .product_i(mul_product),
    .acc_o    (out_acc),
    .count_o  (out_count),
    .ovf_o    (out_ovf)
  );

endmodule

// File: tb/tb_dot_product_sequencer_32.sv
// Directed bench: a 48-bit and a 32-bit accumulator build, each driven by a latency-5 multiplier model.
module tb_dot_product_sequencer_32;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        reset, clear, in_last, in_valid, out_ready;
  logic [31:0] in_a, in_b;

  logic        in_ready, out_ovf, out_valid;
  logic [47:0] out_acc;
  logic [15:0] out_count;
  logic [31:0] mlt0, mcd0, prod0;
  logic        st0, rdy0;
  int          cnt0;

  logic        in_ready32, ovf32, valid32;
  logic [31:0] acc32;
  logic [15:0] cnt32;
  logic [31:0] mlt1, mcd1, prod1;
  logic        st1, rdy1;
  int          cnt1;

  int pass_cnt = 0;
  int total    = 0;
  int start_cnt = 0;
  int hs_cnt = 0;
  bit dbl_start = 1'b0;
  logic st0_prev = 1'b0;

  always #5 clk = ~clk;

  dot_product_sequencer_32 dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .mul_multiplier(mlt0), .mul_multiplicand(mcd0), .mul_start(st0),
    .mul_product(prod0), .mul_ready(rdy0),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  dot_product_sequencer_32 #(.ACC_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready32),
    .mul_multiplier(mlt1), .mul_multiplicand(mcd1), .mul_start(st1),
    .mul_product(prod1), .mul_ready(rdy1),
    .out_acc(acc32), .out_count(cnt32), .out_ovf(ovf32),
    .out_valid(valid32), .out_ready(out_ready)
  );

  // Multiplier models: ready drops on the start edge and returns L edges later with the product.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy0 <= 1'b1; prod0 <= '0; cnt0 <= 0;
    end else if (st0) begin
      rdy0 <= 1'b0; cnt0 <= L;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) begin rdy0 <= 1'b1; prod0 <= mlt0 * mcd0; end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy1 <= 1'b1; prod1 <= '0; cnt1 <= 0;
    end else if (st1) begin
      rdy1 <= 1'b0; cnt1 <= L;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) begin rdy1 <= 1'b1; prod1 <= mlt1 * mcd1; end
    end
  end

  always @(posedge clk) begin
    if (st0) start_cnt++;
    if (st0 && st0_prev) dbl_start = 1'b1;
    st0_prev = st0;
    if (out_valid && out_ready) hs_cnt++;
  end

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last,
                           output bit ok);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic accept_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total++; if (st0 !== 1'b0) $display("FAIL rst_mul_start: got %b want 0", st0); else pass_cnt++;
    total++; if (out_acc !== 48'd0 || out_count !== 16'd0 || out_ovf !== 1'b0)
      $display("FAIL rst_acc: got %0h/%0d/%b want 0/0/0", out_acc, out_count, out_ovf); else pass_cnt++;
    @(negedge clk); reset = 1'b1; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_pre: got %b want 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready_post: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok1, ok2, ok3, okv;
    int s0, h0;
    s0 = start_cnt; h0 = hs_cnt;
    send_pair(32'd3, 32'd4, 1'b0, ok1);
    send_pair(32'd5, -32'sd6, 1'b0, ok2);
    send_pair(32'd7, 32'd8, 1'b1, ok3);
    wait_valid(okv);
    total++; if (!(ok1 && ok2 && ok3 && okv)) $display("FAIL basic_handshake: got %b%b%b%b want 1111", ok1, ok2, ok3, okv); else pass_cnt++;
    total++; if (out_acc !== 48'd38) $display("FAIL basic_acc: got %0h want 26", out_acc); else pass_cnt++;
    total++; if (out_count !== 16'd3) $display("FAIL basic_count: got %0d want 3", out_count); else pass_cnt++;
    total++; if (out_ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", out_ovf); else pass_cnt++;
    total++; if (start_cnt - s0 !== 3) $display("FAIL basic_starts: got %0d want 3", start_cnt - s0); else pass_cnt++;
    total++; if (dbl_start !== 1'b0) $display("FAIL basic_start_width: got %b want 0", dbl_start); else pass_cnt++;
    accept_result();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else pass_cnt++;
    total++; if (hs_cnt - h0 !== 1) $display("FAIL basic_results: got %0d want 1", hs_cnt - h0); else pass_cnt++;
    total++; if (out_acc !== 48'd0 || out_count !== 16'd0) $display("FAIL basic_cleared: got %0h/%0d want 0/0", out_acc, out_count); else pass_cnt++;
  endtask

  task automatic test_single();
    bit ok1, okv;
    send_pair(32'h8000_0000, 32'd1, 1'b1, ok1);
    wait_valid(okv);
    total++; if (!(ok1 && okv)) $display("FAIL single_handshake: got %b%b want 11", ok1, okv); else pass_cnt++;
    total++; if (out_acc !== 48'hFFFF_8000_0000) $display("FAIL single_acc: got %0h want ffff80000000", out_acc); else pass_cnt++;
    total++; if (out_count !== 16'd1) $display("FAIL single_count: got %0d want 1", out_count); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_overflow();
    bit ok1, ok2, okv;
    send_pair(32'h7FFF_FFFF, 32'd1, 1'b0, ok1);
    send_pair(32'd1, 32'd1, 1'b1, ok2);
    wait_valid(okv);
    total++; if (!(ok1 && ok2 && okv && valid32)) $display("FAIL ovf_handshake: got %b%b%b%b want 1111", ok1, ok2, okv, valid32); else pass_cnt++;
    total++; if (acc32 !== 32'h8000_0000) $display("FAIL ovf_acc32: got %0h want 80000000", acc32); else pass_cnt++;
    total++; if (ovf32 !== 1'b1) $display("FAIL ovf_flag32: got %b want 1", ovf32); else pass_cnt++;
    total++; if (cnt32 !== 16'd2) $display("FAIL ovf_count32: got %0d want 2", cnt32); else pass_cnt++;
    total++; if (out_acc !== 48'h0000_8000_0000 || out_ovf !== 1'b0)
      $display("FAIL ovf_acc48: got %0h/%b want 80000000/0", out_acc, out_ovf); else pass_cnt++;
    accept_result();
    total++; if (ovf32 !== 1'b0) $display("FAIL ovf_clear32: got %b want 0", ovf32); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, okv;
    int bad;
    send_pair(32'd1, 32'd2, 1'b1, ok1);
    wait_valid(okv);
    total++; if (!(ok1 && okv)) $display("FAIL bp_handshake: got %b%b want 11", ok1, okv); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_acc !== 48'd2 || in_ready !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else pass_cnt++;
    accept_result();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", out_valid); else pass_cnt++;
    send_pair(32'd3, 32'd3, 1'b1, ok2);
    wait_valid(okv);
    total++; if (!(ok2 && okv)) $display("FAIL bp_next_handshake: got %b%b want 11", ok2, okv); else pass_cnt++;
    total++; if (out_acc !== 48'd9 || out_count !== 16'd1) $display("FAIL bp_next_acc: got %0h/%0d want 9/1", out_acc, out_count); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_clear();
    bit ok1, ok2, ok3, okv, seen_rdy;
    int bad, h0;
    h0 = hs_cnt;
    send_pair(32'd1, 32'd1, 1'b0, ok1);
    send_pair(32'd2, 32'd3, 1'b1, ok2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total++; if (out_acc !== 48'd0 || out_count !== 16'd0) $display("FAIL clr_zero: got %0h/%0d want 0/0", out_acc, out_count); else pass_cnt++;
    bad = 0; seen_rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy0) begin seen_rdy = 1'b1; break; end
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total++; if (!(ok1 && ok2 && seen_rdy)) $display("FAIL clr_handshake: got %b%b%b want 111", ok1, ok2, seen_rdy); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL clr_drain_ready: got %0d busy cycles with in_ready/out_valid want 0", bad); else pass_cnt++;
    send_pair(32'd2, 32'd2, 1'b1, ok3);
    wait_valid(okv);
    total++; if (!(ok3 && okv)) $display("FAIL clr_next_handshake: got %b%b want 11", ok3, okv); else pass_cnt++;
    total++; if (out_acc !== 48'd4 || out_count !== 16'd1) $display("FAIL clr_next_acc: got %0h/%0d want 4/1", out_acc, out_count); else pass_cnt++;
    total++; if (hs_cnt != h0) $display("FAIL clr_no_result: got %0d results want 0", hs_cnt - h0); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_async_reset();
    bit ok1, ok2, ok3, okv;
    send_pair(32'd4, 32'd5, 1'b0, ok1);
    send_pair(32'd6, 32'd7, 1'b1, ok2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (out_acc !== 48'd20) $display("FAIL arst_pre_acc: got %0h want 14", out_acc); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total++; if (out_acc !== 48'd0 || out_count !== 16'd0 || out_ovf !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL arst_outputs: got %0h/%0d/%b/%b want 0/0/0/0", out_acc, out_count, out_ovf, out_valid); else pass_cnt++;
    total++; if (st0 !== 1'b0 || in_ready !== 1'b0 || mlt0 !== 32'd0 || mcd0 !== 32'd0)
      $display("FAIL arst_ctrl: got start=%b rdy=%b a=%0h b=%0h want 0/0/0/0", st0, in_ready, mlt0, mcd0); else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    send_pair(-32'sd3, 32'd7, 1'b1, ok3);
    wait_valid(okv);
    total++; if (!(ok1 && ok2 && ok3 && okv)) $display("FAIL arst_handshake: got %b%b%b%b want 1111", ok1, ok2, ok3, okv); else pass_cnt++;
    total++; if (out_acc !== 48'hFFFF_FFFF_FFEB || out_count !== 16'd1)
      $display("FAIL arst_next_acc: got %0h/%0d want ffffffffffeb/1", out_acc, out_count); else pass_cnt++;
    accept_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer_32.md
Name: dot_product_sequencer_32

Overview:
- Upstream/downstream controller wrapped around the 32-bit integer multiplier wrapper (start/ready/product interface).
- Accepts a stream of signed operand pairs through a valid/ready handshake.
- Issues one multiply per pair and sign-extends and accumulates the products.
- Presents the dot-product result with an element count and a sticky overflow flag on a valid/ready output.

Parameters:
- DATA_WIDTH, 32: operand and product width; must match the multiplier.
- ACC_WIDTH, 48: accumulator width; must be >= DATA_WIDTH.
- CNT_WIDTH, 16: element-counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort/clear, active-high.
- in_a  in  DATA_WIDTH  signed multiplier operand.
- in_b  in  DATA_WIDTH  signed multiplicand operand.
- in_last  in  1  marks the final pair of a vector.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- mul_multiplier  out  DATA_WIDTH  to multiplier.
- mul_multiplicand  out  DATA_WIDTH  to multiplier.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_product  in  DATA_WIDTH  signed product from multiplier.
- mul_ready  in  1  multiplier idle / result valid.
- out_acc  out  ACC_WIDTH  signed dot-product result.
- out_count  out  CNT_WIDTH  number of pairs accumulated.
- out_ovf  out  1  sticky signed overflow of the accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; accumulator, count, ovf and operand registers = 0.
  - mul_start=0, out_valid=0, in_ready=0 while in reset; in_ready=1 from the first clock edge after release.
- States: IDLE, ISSUE, GUARD, WAIT, DONE, DRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register in_a, in_b and in_last, then go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle; go to GUARD.
  - mul_multiplier/mul_multiplicand come from the operand registers and hold stable from ISSUE until leaving WAIT.
- GUARD:
  - One cycle; mul_ready is ignored (multiplier ready deassert latency).
  - Go to WAIT.
- WAIT:
  - On mul_ready=1: acc <= acc + sign_extend(mul_product) modulo 2^ACC_WIDTH; count <= count+1, saturating at all-ones.
  - Set ovf if the signed add overflows (same-sign operands, differing-sign result).
  - Go to DONE if last_r, else IDLE.
- DONE:
  - out_valid=1; out_acc, out_count and out_ovf are stable.
  - On out_ready: clear acc, count and ovf; go to IDLE. A new pair is accepted no earlier than the following cycle.
  - out_valid must not drop without out_ready (except for clear or reset).
- clear (synchronous, highest priority after reset):
  - IDLE/DONE: zero acc, count and ovf; out_valid=0; go to IDLE.
  - ISSUE/GUARD/WAIT: zero acc, count and ovf; go to DRAIN, discarding the in-flight product.
  - DRAIN: in_ready=0; wait for mul_ready=1 with at least one cycle after mul_start, then go to IDLE. clear while in DRAIN has no further effect.
- Simultaneous clear and in_valid in IDLE: clear wins and the pair is not accepted (in_ready=0 that cycle).
- in_last on the first pair: a one-element result (count=1).
- Latency per pair: accept to ISSUE is 1 cycle; ISSUE to WAIT is 2 cycles; then the multiplier latency L; then 1 cycle back to IDLE. Minimum period is 4+L cycles.
- Reset mid-operation: immediate return to reset values. The multiplier is reset by the same signal.

Decomposition:
- Shared package (dotp_pkg):
  - state enum/localparams: IDLE=0, ISSUE=1, GUARD=2, WAIT=3, DONE=4, DRAIN=5.
  - default widths: DATA_WIDTH=32, ACC_WIDTH=48, CNT_WIDTH=16.
- One natural sub-module, dotp_accumulator: sign-extend, add, overflow detect, saturating counter and clear, enabled by an acc_en strobe from the FSM.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, then pairs (3,4),(5,-6),(7,8,last) with a multiplier model of L=5 -> out_acc=12-30+56=38, out_count=3, out_ovf=0, exactly one out_valid; mul_start pulses are one cycle, 3 in total.
- Single pair (-2147483648, 1, last) -> out_acc=0xFFFF_8000_0000 (sign-extended), out_count=1.
- Overflow: ACC_WIDTH=32 build, pairs (0x7FFFFFFF,1),(1,1,last) -> out_acc=0x80000000, out_ovf=1.
- Backpressure: out_ready held low 10 cycles -> out_valid and out_acc stable, in_ready=0 throughout; acceptance on release, next pair accepted afterwards.
- clear asserted in WAIT of the second element -> no result; in_ready=0 until the model raises mul_ready; a subsequent vector (2,2,last) yields out_acc=4, count=1.
- Asynchronous reset mid-WAIT -> all outputs zero immediately, mul_start=0; a normal vector completes correctly after release.
